// File: rtl/prio_encoder_seq_pkg.sv
// Shared definitions for the sequential priority encoder: state encoding and
// the index-width helper used to derive W from N.
package prio_encoder_seq_pkg;

  localparam logic ENC_IDLE = 1'b0;
  localparam logic ENC_EMIT = 1'b1;

  typedef enum logic {
    ST_IDLE = ENC_IDLE,
    ST_EMIT = ENC_EMIT
  } state_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_seq_enc.sv
// Combinational priority encoder: index of the highest set bit, plus
// any-set and exactly-one-set flags.
module prio_enc_comb
  import prio_encoder_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] pend,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         one_hot
);

  // Ascending scan so the highest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) idx = W'(i);
    end
  end

  assign any     = |pend;
  assign one_hot = any && ((pend & (pend - N'(1))) == '0);

endmodule

// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: accepts a request vector and emits the index of
// every set bit, highest first, one per valid/ready beat.
//
// state   | meaning
// IDLE    | waiting for a request vector, in_ready high
// EMIT    | draining pend, one index per accepted beat
module prio_encoder_seq
  import prio_encoder_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         busy
);

  state_e         r_state;
  logic [N-1:0]   r_pend;
  logic [W-1:0]   w_idx;
  logic           w_any;
  logic           w_one_hot;
  logic           w_emit;
  logic           w_xfer;
  logic           w_accept;
  logic [N-1:0]   w_pend_clr;

  prio_enc_comb #(.N(N), .W(W)) u_enc (
    .pend    (r_pend),
    .idx     (w_idx),
    .any     (w_any),
    .one_hot (w_one_hot)
  );

  assign w_emit    = (r_state == ST_EMIT);
  assign out_valid = w_emit;
  assign busy      = w_emit;
  assign out_idx   = w_emit ? w_idx : '0;
  assign out_last  = w_emit & w_one_hot;

  assign w_xfer     = w_emit & out_ready;
  // Final-beat acceptance lets a new vector follow with no idle cycle.
  assign in_ready   = ~w_emit | (w_one_hot & out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_pend_clr = r_pend & ~({{(N-1){1'b0}}, 1'b1} << w_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
    end else if (w_accept) begin
      if (in_req != '0) begin
        r_pend  <= in_req;
        r_state <= ST_EMIT;
      end else begin
        r_pend  <= '0;
        r_state <= ST_IDLE;
      end
    end else if (w_xfer) begin
      r_pend <= w_pend_clr;
      if (w_one_hot || !w_any) r_state <= ST_IDLE;
    end
  end

endmodule
